imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe_if.sv | 25 ++
 rtl/imm_gen_pipe.sv | 146 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator: instruction side, result side and flush.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instruction;
  logic [2:0]      ImmSrc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ImmExt;
  logic [2:0]      ImmFmt;
  logic            ImmIllegal;

  modport master (
    output in_valid, Instruction, ImmSrc, flush, out_ready,
    input  in_ready, out_valid, ImmExt, ImmFmt, ImmIllegal
  );

  modport slave (
    input  in_valid, Instruction, ImmSrc, flush, out_ready,
    output in_ready, out_valid, ImmExt, ImmFmt, ImmIllegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32 immediate decoder feeding a 2-entry FIFO; 1-cycle latency when empty,
// full throughput under out_ready, in_ready drops only when both entries are held.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int AUTO_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_I   = 3'b000;
  localparam logic [2:0] FMT_S   = 3'b001;
  localparam logic [2:0] FMT_B   = 3'b010;
  localparam logic [2:0] FMT_J   = 3'b011;
  localparam logic [2:0] FMT_U   = 3'b100;
  localparam logic [2:0] FMT_ILL = 3'b111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] ext;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  state_t      state;
  state_t      state_nxt;
  logic        in_rdy;
  logic        out_vld;
  logic        push;
  logic        pop;
  logic        rd_ptr;
  logic        wr_ptr;
  entry_t      mem [2];

  logic [31:0]     ins;
  logic [2:0]      dec_fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_ext;
  entry_t          dec_entry;

  assign ins = bus.Instruction;

  // Reserved selects and unmapped opcodes collapse to the illegal format.
  always_comb begin
    dec_fmt = FMT_ILL;
    case (bus.ImmSrc)
      FMT_I, FMT_S, FMT_B, FMT_J, FMT_U: dec_fmt = bus.ImmSrc;
      3'b111: begin
        if (AUTO_EN != 0) begin
          case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0100011:                                     dec_fmt = FMT_S;
            7'b1100011:                                     dec_fmt = FMT_B;
            7'b1101111:                                     dec_fmt = FMT_J;
            7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
            default:                                        dec_fmt = FMT_ILL;
          endcase
        end
      end
      default: dec_fmt = FMT_ILL;
    endcase
  end

  // Build the 32-bit immediate first, then replicate bit 31 up to XLEN.
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    dec_ext       = {XLEN{imm32[31]}};
    dec_ext[31:0] = imm32;
  end

  assign dec_entry = '{ext: dec_ext, fmt: dec_fmt, illegal: (dec_fmt == FMT_ILL)};

  assign push = bus.in_valid & in_rdy;
  assign pop  = out_vld & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = HALF;
        HALF: begin
          if (push && !pop)      state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = HALF;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_rdy  = (state != FULL);
    out_vld = (state != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (bus.flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.ImmExt     = mem[rd_ptr].ext;
  assign bus.ImmFmt     = mem[rd_ptr].fmt;
  assign bus.ImmIllegal = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32-bit and 64-bit instances on one clock.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32), .AUTO_EN(1)) u32 (.clk(clk), .reset(reset), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .AUTO_EN(1)) u64 (.clk(clk), .reset(reset), .bus(b64));

  localparam int NV = 16;
  logic [2:0]  v_src [NV] = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b001, 3'b111, 3'b010, 3'b111,
                              3'b011, 3'b100, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b111};
  logic [31:0] v_ins [NV] = '{32'hFFF00093, 32'h00500093, 32'h00C12083, 32'hFE20AE23,
                              32'hFE20AE23, 32'hFE000EE3, 32'h00000463, 32'hFFDFF06F,
                              32'h0080006F, 32'h123450B7, 32'h80000017, 32'hFFF00093,
                              32'h00000033, 32'hFFFFFFFF, 32'hFFC08067, 32'h00100073};
  logic [31:0] v_ext [NV] = '{32'hFFFFFFFF, 32'h00000005, 32'h0000000C, 32'hFFFFFFFC,
                              32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC,
                              32'h00000008, 32'h12345000, 32'h80000000, 32'h00000000,
                              32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'h00000001};
  logic [2:0]  v_fmt [NV] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                              3'd3, 3'd4, 3'd4, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0};

  localparam int NW = 4;
  logic [2:0]  w_src [NW] = '{3'b111, 3'b111, 3'b000, 3'b011};
  logic [31:0] w_ins [NW] = '{32'h800000B7, 32'h123450B7, 32'hFFF00093, 32'hFFDFF06F};
  logic [63:0] w_ext [NW] = '{64'hFFFFFFFF80000000, 64'h0000000012345000,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC};
  logic [2:0]  w_fmt [NW] = '{3'd4, 3'd4, 3'd0, 3'd3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic vld, input logic [2:0] src, input logic [31:0] ins);
    b32.in_valid    = vld;
    b32.ImmSrc      = src;
    b32.Instruction = ins;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", b32.out_valid); end
    total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", b32.in_ready); end
    total++; if ({b32.ImmExt, b32.ImmFmt, b32.ImmIllegal} !== 36'h0) begin bad++;
      $display("FAIL reset_outputs got ext=%h fmt=%b ill=%b exp all zero", b32.ImmExt, b32.ImmFmt, b32.ImmIllegal); end
    total++; if ({b64.out_valid, b64.ImmExt, b64.ImmFmt, b64.ImmIllegal} !== 69'h0) begin bad++;
      $display("FAIL reset_outputs64 got vld=%b ext=%h exp all zero", b64.out_valid, b64.ImmExt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_formats();
    b32.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive32(1'b1, v_src[i], v_ins[i]);
      tick();
      drive32(1'b0, 3'b000, 32'h0);
      total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL fmt_vld[%0d] got=%b exp=1", i, b32.out_valid); end
      total++; if (b32.ImmExt !== v_ext[i]) begin bad++; $display("FAIL fmt_ext[%0d] got=%h exp=%h", i, b32.ImmExt, v_ext[i]); end
      total++; if ({b32.ImmFmt, b32.ImmIllegal} !== {v_fmt[i], v_fmt[i] == 3'd7}) begin bad++;
        $display("FAIL fmt_sel[%0d] got fmt=%b ill=%b exp fmt=%b", i, b32.ImmFmt, b32.ImmIllegal, v_fmt[i]); end
      tick();
      total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL fmt_drain[%0d] got=%b exp=0", i, b32.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    b32.out_ready = 1'b1;
    for (int i = 3; i < 9; i++) begin
      drive32(1'b1, v_src[i], v_ins[i]);
      tick();
      total++; if ({b32.out_valid, b32.in_ready} !== 2'b11) begin bad++;
        $display("FAIL b2b_hs[%0d] got vld=%b rdy=%b exp 1 1", i, b32.out_valid, b32.in_ready); end
      total++; if ({b32.ImmExt, b32.ImmFmt} !== {v_ext[i], v_fmt[i]}) begin bad++;
        $display("FAIL b2b_data[%0d] got ext=%h fmt=%b exp ext=%h fmt=%b", i, b32.ImmExt, b32.ImmFmt, v_ext[i], v_fmt[i]); end
    end
    drive32(1'b0, 3'b000, 32'h0);
    tick();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", b32.out_valid); end
  endtask

  task automatic test_backpressure();
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b000, 32'h00500093);
    tick();
    total++; if ({b32.out_valid, b32.in_ready, b32.ImmExt} !== {2'b11, 32'h5}) begin bad++;
      $display("FAIL bp_first got vld=%b rdy=%b ext=%h exp 1 1 00000005", b32.out_valid, b32.in_ready, b32.ImmExt); end
    drive32(1'b1, 3'b100, 32'h123450B7);
    tick();
    total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_rdy got=%b exp=0", b32.in_ready); end
    drive32(1'b1, 3'b111, 32'hFE20AE23);
    tick();
    total++; if ({b32.in_ready, b32.ImmExt, b32.ImmFmt} !== {1'b0, 32'h5, 3'd0}) begin bad++;
      $display("FAIL bp_hold got rdy=%b ext=%h fmt=%b exp 0 00000005 000", b32.in_ready, b32.ImmExt, b32.ImmFmt); end
    drive32(1'b0, 3'b000, 32'h0);
    b32.out_ready = 1'b1;
    tick();
    total++; if ({b32.out_valid, b32.in_ready, b32.ImmExt, b32.ImmFmt} !== {2'b11, 32'h12345000, 3'd4}) begin bad++;
      $display("FAIL bp_second got vld=%b rdy=%b ext=%h fmt=%b exp 1 1 12345000 100", b32.out_valid, b32.in_ready, b32.ImmExt, b32.ImmFmt); end
    tick();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_third_dropped got vld=%b exp=0", b32.out_valid); end
  endtask

  task automatic test_flush();
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b000, 32'h00500093);
    tick();
    drive32(1'b1, 3'b100, 32'h123450B7);
    tick();
    total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full got=%b exp=0", b32.in_ready); end
    drive32(1'b1, 3'b001, 32'hFE20AE23);
    b32.flush = 1'b1;
    b32.out_ready = 1'b1;
    tick();
    b32.flush = 1'b0;
    drive32(1'b0, 3'b000, 32'h0);
    total++; if ({b32.out_valid, b32.in_ready} !== 2'b01) begin bad++;
      $display("FAIL flush_state got vld=%b rdy=%b exp 0 1", b32.out_valid, b32.in_ready); end
    tick();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL flush_push_absent got=%b exp=0", b32.out_valid); end
    drive32(1'b1, 3'b101, 32'hFFF00093);
    tick();
    drive32(1'b0, 3'b000, 32'h0);
    total++; if ({b32.out_valid, b32.ImmIllegal, b32.ImmExt, b32.ImmFmt} !== {2'b11, 32'h0, 3'b111}) begin bad++;
      $display("FAIL reserved_src got vld=%b ill=%b ext=%h fmt=%b exp 1 1 00000000 111", b32.out_valid, b32.ImmIllegal, b32.ImmExt, b32.ImmFmt); end
    tick();
  endtask

  task automatic test_reset_midflight();
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b000, 32'hFFF00093);
    tick();
    total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL mid_half got=%b exp=1", b32.out_valid); end
    drive32(1'b1, 3'b100, 32'h123450B7);
    reset = 1'b1;
    tick();
    total++; if ({b32.out_valid, b32.in_ready} !== 2'b01) begin bad++;
      $display("FAIL mid_reset_hs got vld=%b rdy=%b exp 0 1", b32.out_valid, b32.in_ready); end
    total++; if ({b32.ImmExt, b32.ImmFmt, b32.ImmIllegal} !== 36'h0) begin bad++;
      $display("FAIL mid_reset_data got ext=%h fmt=%b ill=%b exp all zero", b32.ImmExt, b32.ImmFmt, b32.ImmIllegal); end
    tick();
    total++; if ({b32.out_valid, b32.in_ready} !== 2'b01) begin bad++;
      $display("FAIL mid_reset_hold got vld=%b rdy=%b exp 0 1", b32.out_valid, b32.in_ready); end
    reset = 1'b0;
    drive32(1'b0, 3'b000, 32'h0);
    b32.out_ready = 1'b1;
    tick();
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_discard got=%b exp=0", b32.out_valid); end
  endtask

  task automatic test_xlen64();
    b64.out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      b64.in_valid    = 1'b1;
      b64.ImmSrc      = w_src[i];
      b64.Instruction = w_ins[i];
      tick();
      b64.in_valid = 1'b0;
      total++; if ({b64.out_valid, b64.ImmExt, b64.ImmFmt} !== {1'b1, w_ext[i], w_fmt[i]}) begin bad++;
        $display("FAIL x64[%0d] got vld=%b ext=%h fmt=%b exp 1 %h %b", i, b64.out_valid, b64.ImmExt, b64.ImmFmt, w_ext[i], w_fmt[i]); end
      tick();
    end
  endtask

  initial begin
    b32.in_valid = 1'b0; b32.ImmSrc = 3'b000; b32.Instruction = 32'h0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.ImmSrc = 3'b000; b64.Instruction = 32'h0; b64.flush = 1'b0; b64.out_ready = 1'b1;
    test_reset();
    test_formats();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
